enemy_bullet_pool: RTL and testbench
====================================

Name: enemy_bullet_pool

Overview:
Fixed pool of enemy projectiles that travel right-to-left toward the player. This is the opposite direction to the player's rightward shot. Enemy AI requests a shot with a req/ack handshake; the pool allocates a free slot, moves all live bullets on a movement tick and detects hits against the player sprite. It also supplies per-pixel overlay colour to the VGA compositor alongside the player-bullet layer.

Parameters:
NUM_SLOTS, 4, number of simultaneously live enemy bullets (1..8)
BULLET_SPEED, 4, pixels moved left per tick
BULLET_SIZE, 4, bullet width and height in pixels
PLAYER_SIZE, 16, player sprite width and height for hit test
COOLDOWN, 8, ticks between accepted shots (must be >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick  input  1  one-cycle movement strobe (frame rate)
fire_req  input  1  enemy requests a shot; held until fire_ack
enemy_x  input  10  enemy sprite X (top-left)
enemy_y  input  9  enemy sprite Y (top-left)
fire_ack  output  1  one-cycle pulse: request accepted
char_x  input  10  player X (top-left)
char_y  input  9  player Y (top-left)
x  input  10  current VGA pixel X
y  input  9  current VGA pixel Y
pixel_on  output  1  a live bullet covers (x,y)
bullet_r  output  8  overlay red
bullet_g  output  8  overlay green
bullet_b  output  8  overlay blue
player_hit  output  1  one-cycle pulse: at least one bullet struck the player
active_mask  output  NUM_SLOTS  per-slot live flags
pool_full  output  1  all slots live

Behaviour:
- Reset (synchronous, active-high):
  - all slots inactive, positions 0, cooldown counter 0
  - fire_ack=0, player_hit=0, active_mask=0, pool_full=0
  - reset mid-flight discards all bullets and any pending request
- Accept condition, evaluated on registered state: fire_req && cooldown==0 && !pool_full && enemy_x >= BULLET_SIZE.
  - If the condition fails, nothing happens and the requester keeps holding fire_req.
- On accept:
  - take the lowest-index inactive slot
  - slot x <= enemy_x - BULLET_SIZE; slot y <= enemy_y + 6 (9-bit); active <= 1
  - cooldown <= COOLDOWN
  - fire_ack pulses high for exactly the next cycle, the same cycle the slot appears in active_mask
- Cooldown:
  - decrements by 1 on each tick while nonzero
  - a reload on accept wins over a decrement in the same cycle
  - COOLDOWN >= 1 prevents a second accept while fire_ack is high
- On tick, per active slot, evaluated with pre-move positions and in priority order:
  1. Hit: bullet box overlaps player box ([char_x, char_x+PLAYER_SIZE) x [char_y, char_y+PLAYER_SIZE)) -> slot inactive; player_hit pulses next cycle (one pulse, even if several slots hit).
  2. Left edge: x < BULLET_SPEED -> slot inactive, no wrap-around.
  3. Otherwise x <= x - BULLET_SPEED.
- Accept and tick in the same cycle: the newly allocated slot is not moved or hit-tested that cycle. A slot freed by that tick is not reusable until the next cycle.
- All range comparisons use 11-bit zero-extended sums, so no 10-bit or 9-bit overflow can occur.
- pool_full = AND of active flags (registered state).
- Render, combinational, zero latency:
  - pixel_on = OR over active slots of (x,y) inside [sx, sx+BULLET_SIZE) x [sy, sy+BULLET_SIZE)
  - colour constant red: r=FF, g=20, b=20, driven regardless of pixel_on
- fire_req dropped before ack: no effect, no state retained.

Decomposition:
- Package game_pkg:
  - SCREEN_W=640, SCREEN_H=480
  - colour constants (ENEMY_BULLET_RGB, PLAYER_BULLET_RGB)
  - typedef slot_t {active, x[9:0], y[8:0]}
- Sub-module box_overlap: combinational half-open rectangle overlap test on two boxes, with parameterized sizes, 11-bit internal math. Instantiated per slot for both render and hit test.

Test Plan:
- Reset, then fire_req=1, enemy_x=300, enemy_y=100 -> fire_ack next cycle; slot0 x=296, y=106; active_mask=0001; cooldown=8.
- Slot0 at x=10, then 3 ticks -> x=6, then 2, then inactive on third tick; no player_hit.
- Slot at x=40, y=106, player at (30,100), tick -> slot cleared, player_hit one-cycle pulse, slot x unchanged before clear.
- Fill 4 slots (tick 8 times between each shot), hold fire_req -> no ack, pool_full=1. Free slot2 via edge -> next eligible request lands in slot2.
- fire_req with cooldown=1 coincident with tick -> not accepted that cycle, accepted next cycle. Accept coincident with tick -> new slot position unmoved.
- Slot at (100,50): pixel (100,50) and (103,53) -> pixel_on=1; (104,50) and (100,54) -> pixel_on=0. Assert reset mid-flight -> active_mask=0 next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants, overlay colours and the projectile slot record.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam logic [23:0] ENEMY_BULLET_RGB  = 24'hFF2020;
  localparam logic [23:0] PLAYER_BULLET_RGB = 24'hFFFF40;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [8:0] y;
  } slot_t;

endpackage

// File: rtl/box_overlap.sv
// Half-open rectangle overlap test between box A and box B, 11-bit math so
// position + size never wraps.
module box_overlap #(
  parameter int unsigned A_W = 4,
  parameter int unsigned A_H = 4,
  parameter int unsigned B_W = 16,
  parameter int unsigned B_H = 16
) (
  input  logic [9:0] i_a_x,
  input  logic [8:0] i_a_y,
  input  logic [9:0] i_b_x,
  input  logic [8:0] i_b_y,
  output logic       o_overlap_c
);

  logic [10:0] w_ax;
  logic [10:0] w_ay;
  logic [10:0] w_bx;
  logic [10:0] w_by;

  assign w_ax = {1'b0, i_a_x};
  assign w_ay = {2'b00, i_a_y};
  assign w_bx = {1'b0, i_b_x};
  assign w_by = {2'b00, i_b_y};

  assign o_overlap_c = (w_ax < (w_bx + 11'(B_W))) && (w_bx < (w_ax + 11'(A_W))) &&
                       (w_ay < (w_by + 11'(B_H))) && (w_by < (w_ay + 11'(A_H)));

endmodule

// File: rtl/enemy_bullet_pool.sv
// Pool of right-to-left enemy bullets: req/ack slot allocation with cooldown,
// tick-driven movement, player hit detection and pixel overlay.
module enemy_bullet_pool
  import game_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = 4,
  parameter int unsigned BULLET_SPEED = 4,
  parameter int unsigned BULLET_SIZE  = 4,
  parameter int unsigned PLAYER_SIZE  = 16,
  parameter int unsigned COOLDOWN     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 fire_req,
  input  logic [9:0]           enemy_x,
  input  logic [8:0]           enemy_y,
  output logic                 fire_ack,
  input  logic [9:0]           char_x,
  input  logic [8:0]           char_y,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  output logic                 pixel_on,
  output logic [7:0]           bullet_r,
  output logic [7:0]           bullet_g,
  output logic [7:0]           bullet_b,
  output logic                 player_hit,
  output logic [NUM_SLOTS-1:0] active_mask,
  output logic                 pool_full
);

  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CD_W  = $clog2(COOLDOWN + 1);

  slot_t                r_slots     [NUM_SLOTS];
  slot_t                w_slots_nxt [NUM_SLOTS];
  logic [CD_W-1:0]      r_cooldown;
  logic [CD_W-1:0]      w_cooldown_nxt;
  logic                 r_fire_ack;
  logic                 r_player_hit;
  logic [NUM_SLOTS-1:0] w_active;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [NUM_SLOTS-1:0] w_pix;
  logic                 w_accept;
  logic                 w_any_hit;
  logic [IDX_W-1:0]     w_free_idx;

  // Per-slot hit test against the player and point test against the beam.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic w_inside;

    assign w_active[gi] = r_slots[gi].active;

    box_overlap #(
      .A_W(BULLET_SIZE), .A_H(BULLET_SIZE), .B_W(PLAYER_SIZE), .B_H(PLAYER_SIZE)
    ) u_hit (
      .i_a_x(r_slots[gi].x), .i_a_y(r_slots[gi].y),
      .i_b_x(char_x),        .i_b_y(char_y),
      .o_overlap_c(w_hit[gi])
    );

    box_overlap #(
      .A_W(BULLET_SIZE), .A_H(BULLET_SIZE), .B_W(1), .B_H(1)
    ) u_pix (
      .i_a_x(r_slots[gi].x), .i_a_y(r_slots[gi].y),
      .i_b_x(x),             .i_b_y(y),
      .o_overlap_c(w_inside)
    );

    assign w_pix[gi] = r_slots[gi].active & w_inside;
  end

  // Lowest-index free slot, from registered state only.
  always_comb begin
    w_free_idx = '0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!r_slots[i].active) w_free_idx = IDX_W'(i);
    end
  end

  assign pool_full = &w_active;
  assign w_accept  = fire_req && (r_cooldown == '0) && !pool_full &&
                     ({1'b0, enemy_x} >= 11'(BULLET_SIZE));

  // Movement/hit on tick uses pre-move positions; allocation overrides a free slot.
  always_comb begin
    w_any_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      w_slots_nxt[i] = r_slots[i];
      if (tick && r_slots[i].active) begin
        if (w_hit[i]) begin
          w_slots_nxt[i].active = 1'b0;
          w_any_hit             = 1'b1;
        end else if ({1'b0, r_slots[i].x} < 11'(BULLET_SPEED)) begin
          w_slots_nxt[i].active = 1'b0;
        end else begin
          w_slots_nxt[i].x = r_slots[i].x - 10'(BULLET_SPEED);
        end
      end
      if (w_accept && (w_free_idx == IDX_W'(i))) begin
        w_slots_nxt[i].active = 1'b1;
        w_slots_nxt[i].x      = enemy_x - 10'(BULLET_SIZE);
        w_slots_nxt[i].y      = enemy_y + 9'd6;
      end
    end
  end

  always_comb begin
    w_cooldown_nxt = r_cooldown;
    if (w_accept) begin
      w_cooldown_nxt = CD_W'(COOLDOWN);
    end else if (tick && (r_cooldown != '0)) begin
      w_cooldown_nxt = r_cooldown - CD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) r_slots[i] <= '0;
      r_cooldown   <= '0;
      r_fire_ack   <= 1'b0;
      r_player_hit <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) r_slots[i] <= w_slots_nxt[i];
      r_cooldown   <= w_cooldown_nxt;
      r_fire_ack   <= w_accept;
      r_player_hit <= w_any_hit;
    end
  end

  assign fire_ack    = r_fire_ack;
  assign player_hit  = r_player_hit;
  assign active_mask = w_active;
  assign pixel_on    = |w_pix;
  assign bullet_r    = ENEMY_BULLET_RGB[23:16];
  assign bullet_g    = ENEMY_BULLET_RGB[15:8];
  assign bullet_b    = ENEMY_BULLET_RGB[7:0];

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Directed bench for enemy_bullet_pool: vector table plus hand-written
// multi-cycle sequences (edge exit, hit, fill/refill, coincident tick, reset).
module tb_enemy_bullet_pool;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       fire_req;
  logic [9:0] enemy_x;
  logic [8:0] enemy_y;
  logic       fire_ack;
  logic [9:0] char_x;
  logic [8:0] char_y;
  logic [9:0] px;
  logic [8:0] py;
  logic       pixel_on;
  logic [7:0] bullet_r;
  logic [7:0] bullet_g;
  logic [7:0] bullet_b;
  logic       player_hit;
  logic [3:0] active_mask;
  logic       pool_full;

  int n_checks = 0;
  int n_errors = 0;

  enemy_bullet_pool dut (
    .clk(clk), .reset(reset), .tick(tick), .fire_req(fire_req),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .fire_ack(fire_ack),
    .char_x(char_x), .char_y(char_y), .x(px), .y(py),
    .pixel_on(pixel_on), .bullet_r(bullet_r), .bullet_g(bullet_g), .bullet_b(bullet_b),
    .player_hit(player_hit), .active_mask(active_mask), .pool_full(pool_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tk;
    logic       fr;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [9:0] cx;
    logic [8:0] cy;
    logic [9:0] vx;
    logic [8:0] vy;
    logic       ack;
    logic [3:0] mask;
    logic       full;
    logic       hit;
    logic       pix;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; fire_req = 1'b0;
    char_x = 10'd600; char_y = 9'd400;
    cyc();
    reset = 1'b0;
  endtask

  logic [9:0] shot_x [4];

  initial begin
    reset = 1'b1; tick = 1'b0; fire_req = 1'b0;
    enemy_x = '0; enemy_y = '0; char_x = 10'd600; char_y = 9'd400; px = '0; py = '0;

    //            rst   tk    fr    ex        ey       cx        cy       x         y        ack   mask     full  hit   pix
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'd300, 9'd100, 10'd600, 9'd400, 10'd0,   9'd0,  1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 10'd3,   9'd44,  10'd600, 9'd400, 10'd0,   9'd0,  1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'd104, 9'd44,  10'd600, 9'd400, 10'd100, 9'd50, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd104, 9'd44,  10'd600, 9'd400, 10'd103, 9'd53, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 10'd104, 9'd44,  10'd600, 9'd400, 10'd104, 9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 10'd104, 9'd44,  10'd600, 9'd400, 10'd100, 9'd54, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 10'd104, 9'd44,  10'd600, 9'd400, 10'd99,  9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'd300, 9'd44,  10'd600, 9'd400, 10'd100, 9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 10'd300, 9'd44,  10'd600, 9'd400, 10'd96,  9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'd300, 9'd44,  10'd600, 9'd400, 10'd100, 9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 10'd300, 9'd44,  10'd80,  9'd40,  10'd92,  9'd50, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 10'd300, 9'd44,  10'd80,  9'd40,  10'd92,  9'd50, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 10'd300, 9'd44,  10'd600, 9'd400, 10'd92,  9'd50, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      reset = vecs[i].rst; tick = vecs[i].tk; fire_req = vecs[i].fr;
      enemy_x = vecs[i].ex; enemy_y = vecs[i].ey;
      char_x = vecs[i].cx; char_y = vecs[i].cy;
      px = vecs[i].vx; py = vecs[i].vy;
      cyc();
      check($sformatf("v%0d_ack", i),  32'(fire_ack),    32'(vecs[i].ack));
      check($sformatf("v%0d_mask", i), 32'(active_mask), 32'(vecs[i].mask));
      check($sformatf("v%0d_full", i), 32'(pool_full),   32'(vecs[i].full));
      check($sformatf("v%0d_hit", i),  32'(player_hit),  32'(vecs[i].hit));
      check($sformatf("v%0d_pix", i),  32'(pixel_on),    32'(vecs[i].pix));
    end
    tick = 1'b0;
    check("colour", 32'({bullet_r, bullet_g, bullet_b}), 32'h00FF2020);

    // Left-edge exit: x=10 -> 6 -> 2 -> gone, no hit.
    do_reset();
    fire_req = 1'b1; enemy_x = 10'd14; enemy_y = 9'd0; px = 10'd10; py = 9'd6;
    cyc();
    fire_req = 1'b0;
    check("edge_ack", 32'(fire_ack), 1);
    check("edge_pix10", 32'(pixel_on), 1);
    px = 10'd6;
    tick_cyc();
    check("edge_pix6", 32'(pixel_on), 1);
    px = 10'd2;
    tick_cyc();
    check("edge_pix2", 32'(pixel_on), 1);
    tick_cyc();
    check("edge_mask", 32'(active_mask), 0);
    check("edge_nohit", 32'(player_hit), 0);

    // Hit: slot (40,106) vs player (30,100).
    do_reset();
    char_x = 10'd30; char_y = 9'd100;
    fire_req = 1'b1; enemy_x = 10'd44; enemy_y = 9'd100; px = 10'd40; py = 9'd106;
    cyc();
    fire_req = 1'b0;
    check("hit_ack", 32'(fire_ack), 1);
    check("hit_prepos", 32'(pixel_on), 1);
    check("hit_early", 32'(player_hit), 0);
    tick_cyc();
    check("hit_mask", 32'(active_mask), 0);
    check("hit_pulse", 32'(player_hit), 1);
    cyc();
    check("hit_pulse_end", 32'(player_hit), 0);

    // Accept coincident with tick: new slot not moved.
    do_reset();
    fire_req = 1'b1; enemy_x = 10'd300; enemy_y = 9'd100; px = 10'd296; py = 9'd106;
    tick = 1'b1;
    cyc();
    tick = 1'b0; fire_req = 1'b0;
    check("co_ack", 32'(fire_ack), 1);
    check("co_pix296", 32'(pixel_on), 1);
    px = 10'd292;
    #1;
    check("co_pix292", 32'(pixel_on), 0);
    cyc();
    check("co_ack_pulse", 32'(fire_ack), 0);

    // Fill the pool with fire_req held; slot2 is placed to leave first.
    do_reset();
    shot_x[0] = 10'd600; shot_x[1] = 10'd600; shot_x[2] = 10'd44; shot_x[3] = 10'd600;
    fire_req = 1'b1; enemy_y = 9'd100;
    for (int s = 0; s < 4; s++) begin
      enemy_x = shot_x[s];
      if (s > 0) begin
        for (int k = 0; k < 8; k++) begin
          tick_cyc();
          check($sformatf("fill%0d_cd%0d_ack", s, k), 32'(fire_ack), 0);
        end
      end
      cyc();
      check($sformatf("fill%0d_ack", s), 32'(fire_ack), 1);
      check($sformatf("fill%0d_mask", s), 32'(active_mask), (1 << (s + 1)) - 1);
    end
    check("fill_full", 32'(pool_full), 1);
    enemy_x = 10'd600; px = 10'd596; py = 9'd106;
    for (int k = 0; k < 8; k++) begin
      tick_cyc();
      check($sformatf("full%0d_ack", k), 32'(fire_ack), 0);
      check($sformatf("full%0d_mask", k), 32'(active_mask), (k >= 2) ? 32'hB : 32'hF);
      check($sformatf("full%0d_full", k), 32'(pool_full), (k >= 2) ? 0 : 1);
    end
    cyc();
    check("refill_ack", 32'(fire_ack), 1);
    check("refill_mask", 32'(active_mask), 32'hF);
    check("refill_pix", 32'(pixel_on), 1);
    check("refill_nohit", 32'(player_hit), 0);

    // Reset mid-flight with a pending request.
    reset = 1'b1;
    cyc();
    check("rst_mask", 32'(active_mask), 0);
    check("rst_ack", 32'(fire_ack), 0);
    check("rst_full", 32'(pool_full), 0);
    reset = 1'b0; enemy_x = 10'd300;
    cyc();
    fire_req = 1'b0;
    check("post_rst_ack", 32'(fire_ack), 1);
    check("post_rst_mask", 32'(active_mask), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
